ada_add_pipe: RTL and testbench
===============================

ADA_ADD_PIPE -- requirements
Module: ada_add_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal 8..64.
REQ-002 Parameter STAGES, default 2, pipeline depth; legal 1..4; WIDTH % STAGES == 0 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 sub  input  1  0 = A+B, 1 = A-B.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block accepts operands this cycle.
REQ-010 c  output  WIDTH  result.
REQ-011 carry  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-012 overflow  output  1  signed two's-complement overflow.
REQ-013 zero  output  1  c == 0.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.

Function
REQ-016 Adder SHALL split into STAGES slices of W/STAGES bits, LSB slice first; slice k adds in stage k using registered carry from stage k-1.
REQ-017 Sub SHALL compute A + ~B + 1; carry-in of slice 0 = sub.
REQ-018 Operand bits not yet consumed SHALL travel alongside the partial result through stage registers; each stage SHALL carry its own valid bit and sub bit.
REQ-019 Global advance enable adv = !out_valid || out_ready; all stages shift when adv = 1, hold otherwise.
REQ-020 in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-021 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-022 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no stall; throughput one result/cycle with out_ready held high.
REQ-023 Bubbles (in_valid = 0 while adv = 1) SHALL shift in as invalid entries.
REQ-024 While out_valid && !out_ready, c, carry, overflow, zero, out_valid SHALL hold stable.
REQ-025 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-026 Wrap-around: result SHALL be modulo 2^WIDTH, no saturation.
REQ-027 zero SHALL be registered with the final stage (not combinational from c).
REQ-028 Inputs sampled only on transfer; changes while in_ready = 0 SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits and drive c, carry, overflow, zero, out_valid to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no result emitted for them.
REQ-031 First transfer possible on first rising edge after rst_n deasserts; in_ready = 1 during and after reset.

Structure
REQ-032 Shared package ada_pkg SHALL hold ADA_WORD_W (32) and op encodings ADA_OP_ADD = 0, ADA_OP_SUB = 1.
REQ-033 One sub-module ada_add_slice SHALL implement one slice adder plus its stage register (data, carry, valid, sub), instantiated STAGES times via generate.
REQ-034 STAGES = 1 SHALL degenerate to a single registered full-width adder with identical handshake.

Verification
REQ-035 WIDTH=32, STAGES=2, out_ready=1: a=0x0000_FFFF, b=0x0000_0001, sub=0 -> after 2 cycles c=0x0001_0000, carry=0, overflow=0, zero=0.
REQ-036 a=0x7FFF_FFFF, b=1, add -> c=0x8000_0000, overflow=1, carry=0; a=0xFFFF_FFFF, b=1 -> c=0, carry=1, zero=1.
REQ-037 sub: a=5, b=5 -> c=0, carry=1, zero=1; a=3, b=5 -> c=0xFFFF_FFFE, carry=0, overflow=0.
REQ-038 Back-to-back 8 operands, out_ready low for cycles 3-5 -> in_ready low same cycles, outputs stable, all 8 results in order, none lost or duplicated.
REQ-039 Reset asserted with 2 ops in flight -> out_valid=0 immediately, no stale result after release; next op returns correct in STAGES cycles.
REQ-040 Random sweep over STAGES in {1,2,4}, WIDTH in {8,32,64}: results match reference model (A±B mod 2^WIDTH plus flags), latency STAGES.

Source files
------------

// File: rtl/ada_add_pipe_pkg.sv
// Shared constants for the segmented add/sub pipeline: default word width and op encodings.
// No logic; imported by the interface, slice and top.
package ada_pkg;
    localparam int   ADA_WORD_W = 32;
    localparam logic ADA_OP_ADD = 1'b0;
    localparam logic ADA_OP_SUB = 1'b1;
endpackage

// File: rtl/ada_add_pipe_if.sv
// Operand/result handshake bundle; master drives operands and out_ready, slave is the adder.
// Both directions use valid/ready; transfer when valid && ready on the rising edge.
interface ada_add_pipe_if
    import ada_pkg::*;
#(
    parameter int WIDTH = ADA_WORD_W
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] c;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, sub, in_valid, out_ready,
        input  in_ready, c, carry, overflow, zero, out_valid
    );

    modport slave (
        input  a, b, sub, in_valid, out_ready,
        output in_ready, c, carry, overflow, zero, out_valid
    );
endinterface

// File: rtl/ada_add_pipe_slice.sv
// One SW-bit slice of the segmented adder plus its stage register; 1 cycle per slice.
// Loads only when adv_i is high, otherwise holds everything (global stall).
module ada_add_slice
    import ada_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 16,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    output logic             vld_o,
    output logic             sub_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] res_o
);
    localparam int LSB = IDX * SW;

    logic [SW-1:0]    a_s;
    logic [SW-1:0]    b_s;
    logic [SW:0]      sum;
    logic [SW-1:0]    low;
    logic [WIDTH-1:0] res_d;

    logic             vld_q, sub_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;

    always_comb begin
        a_s   = a_i[LSB +: SW];
        b_s   = (sub_i == ADA_OP_SUB) ? ~b_i[LSB +: SW] : b_i[LSB +: SW];
        sum   = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, cin_i};
        // low[SW-1] is the carry into this slice's MSB; only meaningful for the top slice
        low   = {1'b0, a_s[SW-2:0]} + {1'b0, b_s[SW-2:0]} + {{(SW-1){1'b0}}, cin_i};
        res_d = res_i;
        res_d[LSB +: SW] = sum[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            sub_q  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
        end else if (adv_i) begin
            vld_q  <= vld_i;
            sub_q  <= sub_i;
            cout_q <= sum[SW];
            ovf_q  <= low[SW-1] ^ sum[SW];
            zero_q <= (res_d == '0);
            a_q    <= a_i;
            b_q    <= b_i;
            res_q  <= res_d;
        end
    end

    assign vld_o  = vld_q;
    assign sub_o  = sub_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;
    assign a_o    = a_q;
    assign b_o    = b_q;
    assign res_o  = res_q;
endmodule

// File: rtl/ada_add_pipe.sv
// Pipelined WIDTH-bit add/sub split into STAGES carry-registered slices; latency STAGES cycles.
// Whole pipe stalls when the result is held (out_valid && !out_ready); in_ready mirrors that.
module ada_add_pipe
    import ada_pkg::*;
#(
    parameter int WIDTH  = ADA_WORD_W,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ada_add_pipe_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("ada_add_pipe: illegal WIDTH/STAGES combination");
    end

    logic             adv;
    logic [STAGES:0]  vld_w, sub_w, cout_w;
    logic [STAGES-1:0] ovf_w, zero_w;
    logic [WIDTH-1:0] a_w   [STAGES+1];
    logic [WIDTH-1:0] b_w   [STAGES+1];
    logic [WIDTH-1:0] res_w [STAGES+1];

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 0 inputs: carry-in of the LSB slice is the sub bit (A + ~B + 1)
    assign vld_w[0]  = bus.in_valid;
    assign sub_w[0]  = bus.sub;
    assign cout_w[0] = bus.sub;
    assign a_w[0]    = bus.a;
    assign b_w[0]    = bus.b;
    assign res_w[0]  = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        ada_add_slice #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .IDX   (k)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv_i  (adv),
            .vld_i  (vld_w[k]),
            .sub_i  (sub_w[k]),
            .cin_i  (cout_w[k]),
            .a_i    (a_w[k]),
            .b_i    (b_w[k]),
            .res_i  (res_w[k]),
            .vld_o  (vld_w[k+1]),
            .sub_o  (sub_w[k+1]),
            .cout_o (cout_w[k+1]),
            .ovf_o  (ovf_w[k]),
            .zero_o (zero_w[k]),
            .a_o    (a_w[k+1]),
            .b_o    (b_w[k+1]),
            .res_o  (res_w[k+1])
        );
    end

    assign bus.out_valid = vld_w[STAGES];
    assign bus.c         = res_w[STAGES];
    assign bus.carry     = cout_w[STAGES];
    assign bus.overflow  = ovf_w[STAGES-1];
    assign bus.zero      = zero_w[STAGES-1];

    // Flags from intermediate slices and fully consumed operands leave the pipe here
    logic unused_tail;
    assign unused_tail = ^{sub_w[STAGES], a_w[STAGES], b_w[STAGES], ovf_w, zero_w};
endmodule

// File: tb/tb_ada_add_pipe.sv
// Bench for ada_add_pipe: directed vectors, stall/reset scenarios, randomized sweep over WIDTH x STAGES.
module tb_ada_add_pipe;
    import ada_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_sw_n, sweep_go;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {zero, overflow, carry, c[63:0]} from plain integer arithmetic
    function automatic logic [66:0] model(int w, logic [63:0] a_in, logic [63:0] b_in, logic op);
        logic [63:0] mask, a, b, c;
        logic [64:0] full;
        logic carry, ovf;
        logic signed [67:0] sa, sb, sr, lim;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (op == ADA_OP_SUB) begin
            full  = {1'b0, a} - {1'b0, b};
            carry = (a >= b);
        end else begin
            full  = {1'b0, a} + {1'b0, b};
            carry = full[w];
        end
        c   = full[63:0] & mask;
        lim = 68'sd1 <<< (w - 1);
        sa  = $signed({4'b0, a});
        sb  = $signed({4'b0, b});
        if (a[w-1]) sa = sa - (lim <<< 1);
        if (b[w-1]) sb = sb - (lim <<< 1);
        sr  = (op == ADA_OP_SUB) ? sa - sb : sa + sb;
        ovf = (sr >= lim) || (sr < -lim);
        return {(c == 64'd0), ovf, carry, c};
    endfunction

    function automatic logic [63:0] pick(int w);
        logic [63:0] r;
        case ($urandom_range(0, 5))
            0: r = 64'd0;
            1: r = {64{1'b1}};
            2: r = 64'd1 << (w - 1);
            3: r = (64'd1 << (w - 1)) - 64'd1;
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // ---------------- directed instance: WIDTH=32, STAGES=2 ----------------
    ada_add_pipe_if #(.WIDTH(32)) mif();
    ada_add_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] exp_c, input logic [2:0] exp_f);
        int n;
        @(negedge clk);
        mif.a = a; mif.b = b; mif.sub = op; mif.in_valid = 1'b1; mif.out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, mif.in_ready, 1);
        @(negedge clk);
        mif.in_valid = 1'b0; mif.a = ~a; mif.b = ~b;
        n = 1;
        while (!mif.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_c"}, mif.c, exp_c);
        chk({tag, "_flags"}, {mif.carry, mif.overflow, mif.zero}, exp_f);
    endtask

    initial begin
        logic [66:0] eq[$];
        logic [66:0] e;
        logic [31:0] oa [8];
        logic [31:0] ob [8];
        logic        os [8];
        logic        prev_stall;
        logic [31:0] snap_c;
        logic [3:0]  snap_f;
        int sent, got, stale, t;

        rst_n = 1'b0; rst_sw_n = 1'b0; sweep_go = 1'b0;
        mif.a = '0; mif.b = '0; mif.sub = 1'b0; mif.in_valid = 1'b0; mif.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", mif.out_valid, 0);
        chk("rst_c", mif.c, 0);
        chk("rst_flags", {mif.carry, mif.overflow, mif.zero}, 0);
        chk("rst_in_ready", mif.in_ready, 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1; rst_sw_n = 1'b1;

        // flags packed as {carry, overflow, zero}
        run_op("carry_slice", 32'h0000_FFFF, 32'h0000_0001, ADA_OP_ADD, 32'h0001_0000, 3'b000);
        run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, ADA_OP_ADD, 32'h8000_0000, 3'b010);
        run_op("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, ADA_OP_ADD, 32'h0000_0000, 3'b101);
        run_op("sub_eq",      32'd5,         32'd5,         ADA_OP_SUB, 32'h0000_0000, 3'b101);
        run_op("sub_borrow",  32'd3,         32'd5,         ADA_OP_SUB, 32'hFFFF_FFFE, 3'b000);
        run_op("sub_ovf",     32'h8000_0000, 32'd1,         ADA_OP_SUB, 32'h7FFF_FFFF, 3'b110);

        // Back-to-back burst with out_ready low for cycles 3..5
        for (int i = 0; i < 8; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; os[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; prev_stall = 1'b0; snap_c = '0; snap_f = '0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            @(negedge clk);
            mif.out_ready = !(i >= 3 && i <= 5);
            mif.in_valid  = (sent < 8);
            mif.a = (sent < 8) ? oa[sent] : 32'hDEAD_BEEF;
            mif.b = (sent < 8) ? ob[sent] : 32'hDEAD_BEEF;
            mif.sub = (sent < 8) ? os[sent] : 1'b0;
            #1;
            if (i >= 3 && i <= 5) chk("burst_rdy_low", mif.in_ready, 0);
            if (prev_stall) begin
                chk("burst_hold_c", mif.c, snap_c);
                chk("burst_hold_f", {mif.out_valid, mif.carry, mif.overflow, mif.zero}, snap_f);
            end
            if (mif.in_valid && mif.in_ready) begin
                eq.push_back(model(32, oa[sent], ob[sent], os[sent]));
                sent++;
            end
            if (mif.out_valid && mif.out_ready) begin
                if (eq.size() == 0) chk("burst_extra", 1, 0);
                else begin
                    e = eq.pop_front();
                    chk("burst_c", mif.c, e[63:0]);
                    chk("burst_flags", {mif.carry, mif.overflow, mif.zero}, {e[64], e[65], e[66]});
                end
                got++;
            end
            prev_stall = mif.out_valid && !mif.out_ready;
            snap_c = mif.c;
            snap_f = {mif.out_valid, mif.carry, mif.overflow, mif.zero};
        end
        chk("burst_count", got, 8);
        @(negedge clk);
        mif.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("burst_no_dup", mif.out_valid, 0);

        // Reset with two operations in flight
        @(negedge clk);
        mif.a = 32'd100; mif.b = 32'd200; mif.sub = ADA_OP_ADD; mif.in_valid = 1'b1; mif.out_ready = 1'b0;
        @(negedge clk);
        mif.a = 32'd7; mif.b = 32'd9;
        @(negedge clk);
        mif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", mif.out_valid, 0);
        chk("midrst_c", mif.c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mif.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 if (mif.out_valid) stale++;
        end
        chk("midrst_stale", stale, 0);
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, ADA_OP_ADD, 32'h2345_6789, 3'b000);

        // Randomized sweep over all WIDTH x STAGES instances
        sweep_go = 1'b1;
        t = 0;
        while (n_done < 9 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_done", n_done, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- sweep instances: WIDTH {8,32,64} x STAGES {1,2,4} ----------------
    for (genvar g = 0; g < 9; g++) begin : g_sw
        localparam int W = (g / 3 == 0) ? 8 : (g / 3 == 1) ? 32 : 64;
        localparam int S = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;

        ada_add_pipe_if #(.WIDTH(W)) sif();
        ada_add_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_sw_n),
            .bus   (sif.slave)
        );

        logic [66:0] eq[$];
        int          ecyc[$];

        initial begin
            logic [63:0] ra, rb;
            logic [66:0] e;
            logic        prev_stall;
            logic [63:0] snap_c;
            logic [3:0]  snap_f;
            int          ec;
            sif.a = '0; sif.b = '0; sif.sub = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b1;
            prev_stall = 1'b0; snap_c = '0; snap_f = '0;
            wait (sweep_go);
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                ra = pick(W); rb = pick(W);
                sif.a = ra[W-1:0];
                sif.b = rb[W-1:0];
                sif.sub = 1'($urandom_range(0, 1));
                sif.in_valid = (cyc < 560) && ($urandom_range(0, 3) != 0);
                sif.out_ready = (cyc < 300 || cyc >= 560) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                chk("sw_rdy", sif.in_ready, !sif.out_valid || sif.out_ready);
                if (prev_stall) begin
                    chk("sw_hold_c", sif.c, snap_c);
                    chk("sw_hold_f", {sif.out_valid, sif.carry, sif.overflow, sif.zero}, snap_f);
                end
                if (sif.in_valid && sif.in_ready) begin
                    eq.push_back(model(W, ra, rb, sif.sub));
                    ecyc.push_back(cyc);
                end
                if (sif.out_valid && sif.out_ready) begin
                    if (eq.size() == 0) chk("sw_extra", 1, 0);
                    else begin
                        e  = eq.pop_front();
                        ec = ecyc.pop_front();
                        chk("sw_c", sif.c, e[63:0]);
                        chk("sw_flags", {sif.carry, sif.overflow, sif.zero}, {e[64], e[65], e[66]});
                        if (cyc < 300) chk("sw_lat", cyc - ec, S);
                    end
                end
                prev_stall = sif.out_valid && !sif.out_ready;
                snap_c = 64'(sif.c);
                snap_f = {sif.out_valid, sif.carry, sif.overflow, sif.zero};
            end
            chk("sw_drain", eq.size(), 0);
            n_done++;
        end
    end
endmodule
